// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and word/address geometry.
package instr_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam int WORD_BYTES = 4;
    // Same byte step the PC uses between consecutive instructions.
    localparam int ADDR_STEP  = 4;

endpackage

// File: rtl/instr_word_packer.sv
// Big-endian byte-to-word packer: shifts accepted bytes in MSB first and flags the byte that completes a word.
module instr_word_packer
    import instr_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);

    logic [31:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            cnt_d = 2'd0;
        end else if (byte_en_i) begin
            shift_d = {shift_q[23:0], byte_i};
            cnt_d   = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign word_o      = shift_q;
    // Asserted in the cycle whose accepted byte is the last of the word.
    assign word_full_o = byte_en_i && !clear_i && (cnt_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/instr_loader.sv
// Instruction memory writer: assembles a byte stream into 32-bit words, writes them at PC-style
// byte addresses, holds busy during the load and pulses done at the end.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int                MEM_WORDS = 64,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                CNT_W     = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(ADDR_STEP);
    localparam logic [ADDR_W-1:0] LIMIT_ADDR = BASE_ADDR + ADDR_W'(ADDR_STEP * MEM_WORDS);

    state_e            state_q;
    logic              byte_ready_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              busy_q;
    logic              done_q;
    logic              overflow_q;
    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  words_q, words_d;

    logic        accept;
    logic        start_ok;
    logic        word_full;
    logic [31:0] word;

    assign accept   = byte_valid && byte_ready_q;
    assign start_ok = start && (state_q == ST_IDLE);
    assign words_d  = words_q + CNT_W'(1);

    instr_word_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (start_ok),
        .byte_en_i   (accept),
        .byte_i      (byte_data),
        .word_o      (word),
        .word_full_o (word_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= BASE_ADDR;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            num_q        <= '0;
            words_q      <= '0;
        end else begin
            done_q  <= 1'b0;
            wr_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        overflow_q <= 1'b0;
                        if (num_words != '0) begin
                            num_q        <= num_words;
                            words_q      <= '0;
                            wr_addr_q    <= BASE_ADDR;
                            busy_q       <= 1'b1;
                            byte_ready_q <= 1'b1;
                            state_q      <= ST_COLLECT;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (word_full) begin
                        byte_ready_q <= 1'b0;
                        state_q      <= ST_WRITE;
                        // Out-of-range words are swallowed so the byte stream stays word-aligned.
                        if (wr_addr_q >= LIMIT_ADDR) begin
                            overflow_q <= 1'b1;
                        end else begin
                            wr_en_q <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    wr_addr_q <= wr_addr_q + STEP;
                    words_q   <= words_d;
                    if (words_d == num_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        byte_ready_q <= 1'b1;
                        state_q      <= ST_COLLECT;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign byte_ready = byte_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = word;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_instr_loader.sv
// Testbench for instr_loader: directed and randomized loads checked against a word-level model.
module tb_instr_loader;

    localparam int MEM_WORDS = 2;
    localparam int ADDR_W    = 32;
    localparam int CNT_W     = 7;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  num_words = '0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = '0;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              done;
    logic              overflow;

    always #5 clk = ~clk;

    instr_loader #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR ('0),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_words  (num_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    int checks = 0;
    int failures = 0;

    logic [63:0] wq[$];
    int          done_cnt = 0;
    int          busy_at_done = 0;
    logic [7:0]  stim [0:31];

    // Observe the memory write port and done pulses between clock edges.
    always @(negedge clk) begin
        if (wr_en) wq.push_back({wr_addr, wr_data});
        if (done) begin
            done_cnt++;
            if (busy) busy_at_done++;
        end
    end

    // Reference model: word w is bytes 4w..4w+3 MSB first, written at byte address 4w.
    function automatic logic [63:0] model_write(input int w);
        logic [31:0] a;
        logic [31:0] d;
        a = 32'(4 * w);
        d = {stim[4*w], stim[4*w+1], stim[4*w+2], stim[4*w+3]};
        return {a, d};
    endfunction

    function automatic int model_nwrites(input int n);
        return (n < MEM_WORDS) ? n : MEM_WORDS;
    endfunction

    task automatic randomize_stim();
        for (int i = 0; i < 32; i++) stim[i] = 8'($urandom);
    endtask

    // Issues a start and feeds bytes; mode 0=continuous, 1=toggling, 2=random valid.
    task automatic run_load(input int n, input int mode, input int restart_at,
                            input int stop_after, output bit timed_out);
        int  idx;
        int  cyc;
        int  nb;
        int  lim;
        int  snap;
        bit  v;
        bit  acc;
        nb = (stop_after >= 0) ? stop_after : 4 * n;
        lim = 8 * nb + 16;
        snap = done_cnt;
        timed_out = 1'b0;
        @(negedge clk);
        start = 1'b1;
        num_words = CNT_W'(n);
        @(negedge clk);
        start = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < nb && cyc < lim) begin
            case (mode)
                0: v = 1'b1;
                1: v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            byte_valid = v;
            byte_data = stim[idx];
            if (restart_at == idx && v) begin
                start = 1'b1;
                num_words = CNT_W'(1);
            end else begin
                start = 1'b0;
            end
            acc = v && byte_ready;
            @(posedge clk);
            if (acc) idx++;
            cyc++;
            @(negedge clk);
        end
        byte_valid = 1'b0;
        start = 1'b0;
        if (idx < nb) timed_out = 1'b1;
        if (stop_after < 0) begin
            cyc = 0;
            while (done_cnt == snap && cyc < 20) begin
                @(posedge clk);
                cyc++;
            end
            if (done_cnt == snap) timed_out = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (byte_ready !== 1'b0) begin failures++; $display("FAIL reset_byte_ready got=%0b exp=0", byte_ready); end
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%0b exp=0", wr_en); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
        checks++; if (wr_addr !== 32'h0) begin failures++; $display("FAIL reset_wr_addr got=%0h exp=0", wr_addr); end
        checks++; if (wr_data !== 32'h0) begin failures++; $display("FAIL reset_wr_data got=%0h exp=0", wr_data); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic(input int mode);
        logic [7:0] seq [0:7];
        bit to;
        int base;
        int dsnap;
        int bsnap;
        seq = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
        for (int i = 0; i < 8; i++) stim[i] = seq[i];
        base = wq.size();
        dsnap = done_cnt;
        bsnap = busy_at_done;
        run_load(2, mode, -1, -1, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL basic%0d_timeout got=1 exp=0", mode); end
        checks++; if (wq.size() - base !== 2) begin failures++; $display("FAIL basic%0d_nwrites got=%0d exp=2", mode, wq.size() - base); end
        if (wq.size() - base >= 2) begin
            checks++; if (wq[base] !== {32'h0, 32'h20080005}) begin failures++; $display("FAIL basic%0d_w0 got=%h exp=%h", mode, wq[base], {32'h0, 32'h20080005}); end
            checks++; if (wq[base+1] !== {32'h4, 32'h20090007}) begin failures++; $display("FAIL basic%0d_w1 got=%h exp=%h", mode, wq[base+1], {32'h4, 32'h20090007}); end
        end
        checks++; if (done_cnt - dsnap !== 1) begin failures++; $display("FAIL basic%0d_done_pulses got=%0d exp=1", mode, done_cnt - dsnap); end
        checks++; if (busy_at_done !== bsnap) begin failures++; $display("FAIL basic%0d_busy_with_done got=%0d exp=%0d", mode, busy_at_done, bsnap); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic%0d_busy_after got=%0b exp=0", mode, busy); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL basic%0d_overflow got=%0b exp=0", mode, overflow); end
    endtask

    task automatic test_zero_words();
        int base;
        base = wq.size();
        @(negedge clk);
        start = 1'b1;
        num_words = '0;
        @(negedge clk);
        start = 1'b0;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done got=%0b exp=1", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy got=%0b exp=0", busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL zero_done_width got=%0b exp=0", done); end
        repeat (3) @(negedge clk);
        checks++; if (wq.size() !== base) begin failures++; $display("FAIL zero_writes got=%0d exp=0", wq.size() - base); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy_after got=%0b exp=0", busy); end
    endtask

    task automatic test_overflow();
        bit to;
        int base;
        int dsnap;
        randomize_stim();
        base = wq.size();
        dsnap = done_cnt;
        run_load(3, 0, -1, -1, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL ovf_timeout got=1 exp=0"); end
        checks++; if (wq.size() - base !== 2) begin failures++; $display("FAIL ovf_nwrites got=%0d exp=2", wq.size() - base); end
        for (int w = 0; w < 2 && base + w < wq.size(); w++) begin
            checks++; if (wq[base+w] !== model_write(w)) begin failures++; $display("FAIL ovf_w%0d got=%h exp=%h", w, wq[base+w], model_write(w)); end
        end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
        checks++; if (done_cnt - dsnap !== 1) begin failures++; $display("FAIL ovf_done got=%0d exp=1", done_cnt - dsnap); end
    endtask

    task automatic test_reset_mid_load();
        bit to;
        int base;
        randomize_stim();
        base = wq.size();
        run_load(2, 0, -1, 6, to);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%0b exp=1", busy); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (wq.size() - base !== 1) begin failures++; $display("FAIL midrst_nwrites got=%0d exp=1", wq.size() - base); end
        checks++; if (wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || byte_ready !== 1'b0 || overflow !== 1'b0)
            begin failures++; $display("FAIL midrst_ctrl got=%b%b%b%b%b exp=00000", wr_en, busy, done, byte_ready, overflow); end
        checks++; if (wr_addr !== 32'h0 || wr_data !== 32'h0) begin failures++; $display("FAIL midrst_data got=%h/%h exp=0/0", wr_addr, wr_data); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (wq.size() - base !== 1) begin failures++; $display("FAIL midrst_no_late_write got=%0d exp=1", wq.size() - base); end
        randomize_stim();
        base = wq.size();
        run_load(1, 0, -1, -1, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL midrst_reload_timeout got=1 exp=0"); end
        checks++; if (wq.size() - base !== 1) begin failures++; $display("FAIL midrst_reload_n got=%0d exp=1", wq.size() - base); end
        if (wq.size() > base) begin
            checks++; if (wq[base] !== model_write(0)) begin failures++; $display("FAIL midrst_reload_w0 got=%h exp=%h", wq[base], model_write(0)); end
        end
    endtask

    task automatic test_restart_ignored();
        bit to;
        int base;
        int dsnap;
        randomize_stim();
        base = wq.size();
        dsnap = done_cnt;
        run_load(2, 0, 5, -1, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL restart_timeout got=1 exp=0"); end
        checks++; if (wq.size() - base !== 2) begin failures++; $display("FAIL restart_nwrites got=%0d exp=2", wq.size() - base); end
        for (int w = 0; w < 2 && base + w < wq.size(); w++) begin
            checks++; if (wq[base+w] !== model_write(w)) begin failures++; $display("FAIL restart_w%0d got=%h exp=%h", w, wq[base+w], model_write(w)); end
        end
        checks++; if (done_cnt - dsnap !== 1) begin failures++; $display("FAIL restart_done got=%0d exp=1", done_cnt - dsnap); end
    endtask

    task automatic test_random_loads();
        bit to;
        int base;
        int dsnap;
        int n;
        int nw;
        for (int it = 0; it < 8; it++) begin
            randomize_stim();
            n = $urandom_range(1, 4);
            nw = model_nwrites(n);
            base = wq.size();
            dsnap = done_cnt;
            run_load(n, 2, -1, -1, to);
            checks++; if (to !== 1'b0) begin failures++; $display("FAIL rand%0d_timeout n=%0d got=1 exp=0", it, n); end
            checks++; if (wq.size() - base !== nw) begin failures++; $display("FAIL rand%0d_nwrites got=%0d exp=%0d", it, wq.size() - base, nw); end
            for (int w = 0; w < nw && base + w < wq.size(); w++) begin
                checks++; if (wq[base+w] !== model_write(w)) begin failures++; $display("FAIL rand%0d_w%0d got=%h exp=%h", it, w, wq[base+w], model_write(w)); end
            end
            checks++; if (overflow !== 1'(n > MEM_WORDS)) begin failures++; $display("FAIL rand%0d_overflow got=%0b exp=%0b", it, overflow, n > MEM_WORDS); end
            checks++; if (done_cnt - dsnap !== 1) begin failures++; $display("FAIL rand%0d_done got=%0d exp=1", it, done_cnt - dsnap); end
        end
    endtask

    initial begin
        test_reset();
        test_basic(0);
        test_basic(1);
        test_zero_words();
        test_overflow();
        test_reset_mid_load();
        test_restart_ignored();
        test_random_loads();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
